// File: rtl/vga_capture.sv
// vga_capture: receive end of the 640x400 VGA path. Registers the incoming
// sync/DE/RGB, measures active width and height, locks onto a stable frame
// geometry and, once locked, decimates H_DIV x V_DIV into RGB332 write
// strobes that fill a MAX_W x MAX_H byte frame store.
//
// Write port handshake: wr_en is a single-cycle strobe. wr_addr and wr_data
// are valid in exactly the cycles where wr_en is high. There is no back-pressure:
// the frame store must accept one write per strobe.
module vga_capture #(
  parameter int unsigned H_DIV  = 4,
  parameter int unsigned V_DIV  = 4,
  parameter int unsigned MAX_W  = 160,
  parameter int unsigned MAX_H  = 100,
  parameter int unsigned ADDR_W = 14,
  parameter bit          HS_POL = 1'b0,
  parameter bit          VS_POL = 1'b1
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              de_in,
  input  logic [7:0]        r_in,
  input  logic [7:0]        g_in,
  input  logic [7:0]        b_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              locked,
  output logic [9:0]        h_active,
  output logic [9:0]        v_active,
  output logic              frame_done,
  output logic [1:0]        dbg_state
);

  localparam int unsigned H_SH   = $clog2(H_DIV);
  localparam int unsigned V_SH   = $clog2(V_DIV);
  localparam logic [9:0]  H_MASK = 10'(H_DIV - 1);
  localparam logic [9:0]  V_MASK = 10'(V_DIV - 1);
  localparam logic [9:0]  W_LIM  = 10'(MAX_W);
  localparam logic [9:0]  H_LIM  = 10'(MAX_H);
  localparam logic [9:0]  SAT    = 10'h3ff;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    VERIFY  = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  // Input stage (stage 1) and edge-detect stage (stage 2)
  logic              hs1_q, hs1_d;
  logic              vs1_q, vs1_d;
  logic              de1_q, de1_d;
  logic [2:0]        r1_q, r1_d;
  logic [2:0]        g1_q, g1_d;
  logic [1:0]        b1_q, b1_d;
  logic              vs2_q, vs2_d;
  logic              de2_q, de2_d;

  // Geometry measurement
  logic [9:0]        col_q, col_d;
  logic [9:0]        row_q, row_d;
  logic              line_valid_q, line_valid_d;
  logic [9:0]        h_active_q, h_active_d;
  logic [9:0]        v_active_q, v_active_d;
  logic [9:0]        ref_h_q, ref_h_d;
  logic [9:0]        ref_v_q, ref_v_d;

  // Lock FSM and registered outputs
  state_t            state_q, state_d;
  logic              locked_q, locked_d;
  logic              frame_done_q, frame_done_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  // Combinational helpers
  logic              vs_act1, vs_act2, vs_edge;
  logic              de_rise, de_fall;
  logic [9:0]        cur_col;
  logic              line_ok;
  logic [9:0]        cdiv, rdiv;
  logic              geo_match;
  logic [ADDR_W-1:0] addr_calc;

  // HS carries no information this block needs; only the colour MSBs that
  // survive the RGB332 packing are registered.
  logic unused_inputs;
  assign unused_inputs = ^{hs1_q == HS_POL, r_in[4:0], g_in[4:0], b_in[5:0]};

  // Next-state logic: input stage, measurement counters, lock FSM, write port
  always_comb begin
    // edge detection between stage 1 and stage 2
    vs_act1 = (vs1_q == VS_POL);
    vs_act2 = (vs2_q == VS_POL);
    vs_edge = vs_act1 & ~vs_act2;
    de_rise = de1_q & ~de2_q;
    de_fall = ~de1_q & de2_q;

    // column index of the pixel now in stage 1; a new line starts at 0
    cur_col = de_rise ? 10'd0 : col_q;
    // a line opened while VS is active is ignored for its whole length
    line_ok = de_rise ? ~vs_act1 : line_valid_q;
    cdiv    = cur_col >> H_SH;
    rdiv    = row_q >> V_SH;
    // row_q is the line count of the frame that is just ending
    geo_match = (h_active_q == ref_h_q) && (row_q == ref_v_q);
    // (row/V_DIV)*160 as x128 + x32; only MAX_W = 160 is supported
    addr_calc = (ADDR_W'(rdiv) << 7) + (ADDR_W'(rdiv) << 5) + ADDR_W'(cdiv);

    hs1_d = hs_in;
    vs1_d = vs_in;
    de1_d = de_in;
    r1_d  = r_in[7:5];
    g1_d  = g_in[7:5];
    b1_d  = b_in[7:6];
    vs2_d = vs1_q;
    de2_d = de1_q;

    col_d        = col_q;
    row_d        = row_q;
    line_valid_d = line_valid_q;
    h_active_d   = h_active_q;
    v_active_d   = v_active_q;
    ref_h_d      = ref_h_q;
    ref_v_d      = ref_v_q;
    state_d      = state_q;
    frame_done_d = 1'b0;

    // pixel counter, saturating
    if (de1_q) begin
      col_d = (cur_col == SAT) ? SAT : cur_col + 10'd1;
    end

    // a VS assertion terminates any open line
    if (de_rise) begin
      line_valid_d = ~vs_act1;
    end else if (vs_edge) begin
      line_valid_d = 1'b0;
    end

    // completed line: record width and advance the line counter
    if (de_fall && line_valid_q && !vs_edge) begin
      h_active_d = col_q;
      if (row_q != SAT) begin
        row_d = row_q + 10'd1;
      end
    end

    // frame boundary: record height and step the lock FSM
    if (vs_edge) begin
      row_d      = 10'd0;
      v_active_d = row_q;
      case (state_q)
        SEARCH:  state_d = MEASURE;
        MEASURE: begin
          if ((h_active_q != 10'd0) && (row_q != 10'd0)) begin
            ref_h_d = h_active_q;
            ref_v_d = row_q;
            state_d = VERIFY;
          end
        end
        VERIFY:  state_d = geo_match ? LOCKED : MEASURE;
        LOCKED: begin
          if (geo_match) begin
            frame_done_d = 1'b1;
          end else begin
            state_d = MEASURE;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    locked_d = (state_d == LOCKED);

    // store one pixel per H_DIV x V_DIV block inside the frame-store window
    wr_en_d = de1_q && line_ok && !vs_act1 &&
              ((cur_col & H_MASK) == 10'd0) &&
              ((row_q & V_MASK) == 10'd0) &&
              (cdiv < W_LIM) && (rdiv < H_LIM) &&
              (state_q == LOCKED);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_en_d) begin
      wr_addr_d = addr_calc;
      wr_data_d = {r1_q, g1_q, b1_q};
    end
  end

  // State registers; reset clears everything and returns the FSM to SEARCH
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hs1_q        <= 1'b0;
      vs1_q        <= 1'b0;
      de1_q        <= 1'b0;
      r1_q         <= '0;
      g1_q         <= '0;
      b1_q         <= '0;
      vs2_q        <= 1'b0;
      de2_q        <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      line_valid_q <= 1'b0;
      h_active_q   <= '0;
      v_active_q   <= '0;
      ref_h_q      <= '0;
      ref_v_q      <= '0;
      state_q      <= SEARCH;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      hs1_q        <= hs1_d;
      vs1_q        <= vs1_d;
      de1_q        <= de1_d;
      r1_q         <= r1_d;
      g1_q         <= g1_d;
      b1_q         <= b1_d;
      vs2_q        <= vs2_d;
      de2_q        <= de2_d;
      col_q        <= col_d;
      row_q        <= row_d;
      line_valid_q <= line_valid_d;
      h_active_q   <= h_active_d;
      v_active_q   <= v_active_d;
      ref_h_q      <= ref_h_d;
      ref_v_q      <= ref_v_d;
      state_q      <= state_d;
      locked_q     <= locked_d;
      frame_done_q <= frame_done_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign locked     = locked_q;
  assign h_active   = h_active_q;
  assign v_active   = v_active_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: frame-level directed vectors for vga_capture. Each table
// record describes one frame (geometry plus optional mid-line VS cut or
// mid-frame reset) and the lock/measurement values expected after its VS.
// Frames use short blanking so that many frames fit in the cycle budget.
module tb_vga_capture;

  localparam int ADDR_W = 14;

  // clock/reset block
  logic              pclk = 1'b0;
  logic              reset;
  logic              hs_in, vs_in, de_in;
  logic [7:0]        r_in, g_in, b_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              locked;
  logic [9:0]        h_active, v_active;
  logic              frame_done;
  logic [1:0]        dbg_state;

  always #5 pclk = ~pclk;

  vga_capture dut (
    .pclk       (pclk),
    .reset      (reset),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .de_in      (de_in),
    .r_in       (r_in),
    .g_in       (g_in),
    .b_in       (b_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .locked     (locked),
    .h_active   (h_active),
    .v_active   (v_active),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  typedef struct {
    int w;
    int h;
    int cut_row;
    int cut_pix;
    int rst_row;
    int rst_pix;
    bit exp_locked;
    bit exp_fd;
    int exp_h;
    int exp_v;
  } vec_t;

  int                      tests_run    = 0;
  int                      tests_failed = 0;
  logic [ADDR_W+7:0]       exp_q[$];
  logic [ADDR_W+7:0]       exp_item;
  int                      fd_cnt   = 0;
  bit                      storing  = 1'b0;
  int                      carry_de = 0;
  vec_t                    vecs[$];

  function automatic vec_t mk(int w, int h, int cut_row, int cut_pix, int rst_row, int rst_pix,
                              bit lk, bit fd, int eh, int ev);
    vec_t v;
    v.w = w; v.h = h; v.cut_row = cut_row; v.cut_pix = cut_pix;
    v.rst_row = rst_row; v.rst_pix = rst_pix;
    v.exp_locked = lk; v.exp_fd = fd; v.exp_h = eh; v.exp_v = ev;
    return v;
  endfunction

  // pixel value model: stored pixels (col % 4 == 0) carry col/4
  function automatic logic [7:0] pix(int c);
    return 8'((c >> 2) + (c & 3) * 64);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_wr"}, int'({wr_en, wr_addr, wr_data}), 0);
    check({tag, "_lock_fd"}, int'({locked, frame_done}), 0);
    check({tag, "_h_active"}, int'(h_active), 0);
    check({tag, "_v_active"}, int'(v_active), 0);
  endtask

  // driver: one pixel clock of stimulus
  task automatic drive(input bit de, input bit vs, input bit hs, input int col);
    logic [7:0] p;
    @(posedge pclk);
    #1;
    p = pix(col);
    de_in = de;
    vs_in = vs;
    hs_in = hs;
    r_in  = {p[7:5], p[7:5], p[7:6]};
    g_in  = {p[4:2], p[4:2], p[4:3]};
    b_in  = {p[1:0], p[1:0], p[1:0], p[1:0]};
  endtask

  // driver: one line (w active + 8 blanking), optional early stop, reset, DE carry
  task automatic send_line(input int w, input bit active, input bit vs, input int row,
                           input int stop_pix, input int rst_pix, input int carry);
    int len;
    bit de;
    bit hs;
    len = (stop_pix >= 0) ? stop_pix : w + 8;
    for (int c = 0; c < len; c++) begin
      de = (active && c < w) || (c < carry);
      hs = !(c >= w + 2 && c < w + 5);
      drive(de, vs, hs, c);
      if (rst_pix >= 0 && c == rst_pix) begin
        #1;
        reset = 1'b1;
        #1;
        check_zero_outputs("mid_reset");
        storing = 1'b0;
      end
      if (rst_pix >= 0 && c == rst_pix + 2) reset = 1'b0;
      if (active && storing && c < w && (c % 4) == 0 && (row % 4) == 0 &&
          (c / 4) < 160 && (row / 4) < 100)
        exp_q.push_back({14'((row / 4) * 160 + c / 4), pix(c)});
    end
  endtask

  // one frame: VS (2 lines), VBP (2), active lines, VFP (1)
  task automatic run_frame(input int idx, input vec_t v);
    int carry_now;
    bit cut;
    carry_now = carry_de;
    carry_de  = 0;
    fd_cnt    = 0;
    storing   = 1'b0;
    cut       = 1'b0;
    send_line(v.w, 1'b0, 1'b1, 0, -1, -1, carry_now);
    send_line(v.w, 1'b0, 1'b1, 0, -1, -1, 0);
    check($sformatf("v%0d_locked", idx), int'(locked), int'(v.exp_locked));
    check($sformatf("v%0d_h_active", idx), int'(h_active), v.exp_h);
    check($sformatf("v%0d_v_active", idx), int'(v_active), v.exp_v);
    storing = v.exp_locked;
    send_line(v.w, 1'b0, 1'b0, 0, -1, -1, 0);
    send_line(v.w, 1'b0, 1'b0, 0, -1, -1, 0);
    for (int r = 0; r < v.h; r++) begin
      if (r == v.cut_row) begin
        send_line(v.w, 1'b1, 1'b0, r, v.cut_pix, -1, 0);
        carry_de = v.w - v.cut_pix;
        cut = 1'b1;
        break;
      end
      send_line(v.w, 1'b1, 1'b0, r, -1, (r == v.rst_row) ? v.rst_pix : -1, 0);
    end
    if (!cut) send_line(v.w, 1'b0, 1'b0, 0, -1, -1, 0);
    check($sformatf("v%0d_frame_done_count", idx), fd_cnt, int'(v.exp_fd));
    check($sformatf("v%0d_pending_writes", idx), exp_q.size(), 0);
    exp_q.delete();
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge pclk) begin
    if (!reset) begin
      if (frame_done) fd_cnt++;
      if (wr_en) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_write: addr %0d data %02h, no write expected", wr_addr, wr_data);
        end else begin
          exp_item = exp_q.pop_front();
          if ({wr_addr, wr_data} != exp_item) begin
            tests_failed++;
            $display("FAIL write_compare: addr %0d data %02h, expected addr %0d data %02h",
                     wr_addr, wr_data, exp_item[ADDR_W+7:8], exp_item[7:0]);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    de_in = 1'b0; vs_in = 1'b0; hs_in = 1'b1;
    r_in = '0; g_in = '0; b_in = '0;
    repeat (3) @(posedge pclk);
    #2;
    check_zero_outputs("init_reset");
    @(posedge pclk);
    #1;
    reset = 1'b0;
    repeat (4) drive(1'b0, 1'b0, 1'b1, 0);

    // w, h, cut_row, cut_pix, rst_row, rst_pix, locked, frame_done, h_active, v_active
    vecs.push_back(mk( 24,  16, -1, -1, -1, -1, 0, 0,   0,   0)); // SEARCH -> MEASURE
    vecs.push_back(mk( 24,  16, -1, -1, -1, -1, 0, 0,  24,  16)); // -> VERIFY
    vecs.push_back(mk( 24,  16, -1, -1, -1, -1, 1, 0,  24,  16)); // lock at 3rd VS
    vecs.push_back(mk( 24,  16, -1, -1, -1, -1, 1, 1,  24,  16));
    vecs.push_back(mk( 12,  16, -1, -1, -1, -1, 1, 1,  24,  16)); // narrower frame still stored
    vecs.push_back(mk( 12,  16, -1, -1, -1, -1, 0, 0,  12,  16)); // width change drops lock
    vecs.push_back(mk( 12,  16, -1, -1, -1, -1, 0, 0,  12,  16));
    vecs.push_back(mk( 12,  16, -1, -1, -1, -1, 1, 0,  12,  16)); // relock
    vecs.push_back(mk( 12,  16, -1, -1, -1, -1, 1, 1,  12,  16));
    vecs.push_back(mk(700,   8, -1, -1, -1, -1, 1, 1,  12,  16)); // column clipping
    vecs.push_back(mk(  8, 410, -1, -1, -1, -1, 0, 0, 700,   8));
    vecs.push_back(mk(  8, 410, -1, -1, -1, -1, 0, 0,   8, 410));
    vecs.push_back(mk(  8, 410, -1, -1, -1, -1, 1, 0,   8, 410)); // row clipping
    vecs.push_back(mk( 24,  16, -1, -1, -1, -1, 1, 1,   8, 410));
    vecs.push_back(mk( 24,  16, -1, -1, -1, -1, 0, 0,  24,  16));
    vecs.push_back(mk( 24,  16, -1, -1, -1, -1, 0, 0,  24,  16));
    vecs.push_back(mk( 24,  16, -1, -1, -1, -1, 1, 0,  24,  16));

    for (int i = 0; i < vecs.size(); i++) run_frame(i, vecs[i]);

    // VS asserted mid-line: line 9 stops at pixel 10, DE runs on into VS
    run_frame(17, mk(24, 16, 9, 10, -1, -1, 1, 1, 24, 16));
    run_frame(18, mk(24, 16, -1, -1, -1, -1, 0, 0, 24, 9));
    run_frame(19, mk(24, 16, -1, -1, -1, -1, 0, 0, 24, 16));
    run_frame(20, mk(24, 16, -1, -1, -1, -1, 1, 0, 24, 16));

    // reset at line 8, pixel 12 of a locked frame, then full relock
    run_frame(21, mk(24, 16, -1, -1, 8, 12, 1, 1, 24, 16));
    run_frame(22, mk(24, 16, -1, -1, -1, -1, 0, 0, 24, 8));
    run_frame(23, mk(24, 16, -1, -1, -1, -1, 0, 0, 24, 16));
    run_frame(24, mk(24, 16, -1, -1, -1, -1, 1, 0, 24, 16));
    run_frame(25, mk(24, 16, -1, -1, -1, -1, 1, 1, 24, 16));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
